// File: rtl/pcseq_pkg.sv
// Shared types for the program-counter sequencer: opcode and FSM state encodings.
package pcseq_pkg;

  localparam int PCSEQ_OP_W = 3;

  typedef enum logic [PCSEQ_OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HALT   = 3'd5
  } pcseq_op_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } pcseq_state_e;

endpackage

// File: rtl/pcseq_depth_ctr.sv
// Call-depth counter with overflow/underflow compare.
// Limit checks exist only when PCSEQ_DEPTH_CHECK_EN is defined; otherwise depth wraps.
module pcseq_depth_ctr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         call,
  input  logic         ret,
  output logic [W-1:0] depth,
  output logic         ovf,
  output logic         unf
);

`ifdef PCSEQ_DEPTH_CHECK_EN
  // Slot 0 is the base entry, so the deepest legal value is all ones.
  assign ovf = call && (depth == {W{1'b1}});
  assign unf = ret && (depth == '0);
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
    end else if (call && !ovf) begin
      depth <= depth + 1'b1;
    end else if (ret && !unf) begin
      depth <= depth - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, executes control-flow ops, drives the return-address stack.
// Optional depth fault checking is enabled with PCSEQ_DEPTH_CHECK_EN.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int INSTRUCTION_ADDR_SIZE = 10,
  parameter int STACK_PTR_WIDTH       = 6,
  parameter int RESET_PC              = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [2:0]                       op_code,
  input  logic [INSTRUCTION_ADDR_SIZE-1:0] op_target,
  input  logic                             op_cond,
  input  logic                             resume,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] pc,
  output logic [INSTRUCTION_ADDR_SIZE-1:0] stk_addr,
  output logic                             stk_push,
  output logic                             stk_en,
  input  logic [INSTRUCTION_ADDR_SIZE-1:0] stk_top,
  output logic [STACK_PTR_WIDTH-1:0]       depth,
  output logic                             halted,
  output logic                             fault
);

  localparam int IAS = INSTRUCTION_ADDR_SIZE;

  pcseq_state_e   state;
  logic           accept;
  logic           is_call;
  logic           is_ret;
  logic           ovf;
  logic           unf;
  logic           err;
  logic [IAS-1:0] pc_inc;

  // Handshake: an op transfers on the cycle op_valid && op_ready are both high;
  // op_ready depends only on state (and rst), never on op_valid.
  assign op_ready = (state == ST_RUN) && !rst;
  assign accept   = op_valid && op_ready;
  assign is_call  = accept && (op_code == OP_CALL);
  assign is_ret   = accept && (op_code == OP_RET);
  assign pc_inc   = pc + 1'b1;

  pcseq_depth_ctr #(
    .W(STACK_PTR_WIDTH)
  ) u_depth (
    .clk  (clk),
    .rst  (rst),
    .call (is_call),
    .ret  (is_ret),
    .depth(depth),
    .ovf  (ovf),
    .unf  (unf)
  );

  assign err      = ovf || unf;
  assign stk_en   = (is_call || is_ret) && !err;
  assign stk_push = is_call;
  assign stk_addr = pc_inc;
  assign halted   = (state == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= IAS'(RESET_PC);
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (err) begin
              state <= ST_FAULT;
            end else begin
              case (op_code)
                OP_JUMP:   pc <= op_target;
                OP_BRANCH: pc <= op_cond ? op_target : pc_inc;
                OP_CALL:   pc <= op_target;
                OP_RET:    pc <= stk_top;
                OP_HALT:   state <= ST_HALTED;
                default:   pc <= pc_inc;
              endcase
            end
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state <= ST_RUN;
            pc    <= pc_inc;
          end
        end
        default: begin
          // FAULT holds everything until reset.
        end
      endcase
    end
  end

`ifdef PCSEQ_DEPTH_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (accept && err) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; covers both builds of PCSEQ_DEPTH_CHECK_EN.
module tb_pc_sequencer;
  import pcseq_pkg::*;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [9:0] op_target;
  logic       op_cond;
  logic       resume;
  logic [9:0] pc;
  logic [9:0] stk_addr;
  logic       stk_push;
  logic       stk_en;
  logic [9:0] stk_top;
  logic [5:0] depth;
  logic       halted;
  logic       fault;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {depth, pc} expected after the edge.
  logic [15:0] exp_q[$];

  logic [9:0] m_pc;
  logic [5:0] m_depth;
  logic       m_halted;
  logic       m_fault;
  logic [9:0] m_stack[64];

  // Return-address stack the sequencer drives.
  logic [9:0] ras[64];
  logic [5:0] sp;

  pc_sequencer #(
    .INSTRUCTION_ADDR_SIZE(10),
    .STACK_PTR_WIDTH      (6),
    .RESET_PC             (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_target(op_target),
    .op_cond  (op_cond),
    .resume   (resume),
    .pc       (pc),
    .stk_addr (stk_addr),
    .stk_push (stk_push),
    .stk_en   (stk_en),
    .stk_top  (stk_top),
    .depth    (depth),
    .halted   (halted),
    .fault    (fault)
  );

  // Clock / reset-driven environment
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 6'd0;
    end else if (stk_en) begin
      if (stk_push) begin
        ras[sp + 6'd1] <= stk_addr;
        sp             <= sp + 6'd1;
      end else begin
        sp <= sp - 6'd1;
      end
    end
  end
  assign stk_top = ras[sp];

  task automatic model_reset();
    m_pc     = 10'd0;
    m_depth  = 6'd0;
    m_halted = 1'b0;
    m_fault  = 1'b0;
    exp_q.delete();
  endtask

  task automatic compare_after_edge(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (pc !== e[9:0]) begin
        errors++;
        $display("FAIL %s pc: got %0h expected %0h", name, pc, e[9:0]);
      end
      checks++;
      if (depth !== e[15:10]) begin
        errors++;
        $display("FAIL %s depth: got %0d expected %0d", name, depth, e[15:10]);
      end
      checks++;
      if (halted !== m_halted || fault !== m_fault) begin
        errors++;
        $display("FAIL %s flags: got halted=%b fault=%b expected halted=%b fault=%b",
                 name, halted, fault, m_halted, m_fault);
      end
    end
  endtask

  // Driver: one op for one cycle, with model prediction pushed on drive.
  task automatic send_op(input logic [2:0] code, input logic [9:0] tgt, input logic cond,
                         input string name);
    logic [9:0] npc;
    logic [5:0] nd;
    logic       nf;
    logic       nh;
    logic       acc;
    logic       exp_en;
    logic       exp_push;
    logic [9:0] exp_addr;
    npc      = m_pc;
    nd       = m_depth;
    nf       = m_fault;
    nh       = m_halted;
    acc      = !m_halted && !m_fault;
    exp_en   = 1'b0;
    exp_push = 1'b0;
    exp_addr = m_pc + 10'd1;
    if (acc) begin
      case (code)
        3'd1: npc = tgt;
        3'd2: npc = cond ? tgt : m_pc + 10'd1;
        3'd3: begin
`ifdef PCSEQ_DEPTH_CHECK_EN
          if (m_depth == 6'd63) nf = 1'b1; else
`endif
          begin
            npc                      = tgt;
            m_stack[m_depth + 6'd1]  = m_pc + 10'd1;
            nd                       = m_depth + 6'd1;
            exp_en                   = 1'b1;
            exp_push                 = 1'b1;
          end
        end
        3'd4: begin
`ifdef PCSEQ_DEPTH_CHECK_EN
          if (m_depth == 6'd0) nf = 1'b1; else
`endif
          begin
            npc    = m_stack[m_depth];
            nd     = m_depth - 6'd1;
            exp_en = 1'b1;
          end
        end
        3'd5: nh = 1'b1;
        default: npc = m_pc + 10'd1;
      endcase
    end
    @(negedge clk);
    op_valid  = 1'b1;
    op_code   = code;
    op_target = tgt;
    op_cond   = cond;
    exp_q.push_back({nd, npc});
    #1;
    checks++;
    if (op_ready !== acc) begin
      errors++;
      $display("FAIL %s op_ready: got %b expected %b", name, op_ready, acc);
    end
    checks++;
    if (stk_en !== exp_en) begin
      errors++;
      $display("FAIL %s stk_en: got %b expected %b", name, stk_en, exp_en);
    end
    if (exp_en) begin
      checks++;
      if (stk_push !== exp_push || (exp_push && stk_addr !== exp_addr)) begin
        errors++;
        $display("FAIL %s stack port: got push=%b addr=%0h expected push=%b addr=%0h",
                 name, stk_push, stk_addr, exp_push, exp_addr);
      end
    end
    m_pc     = npc;
    m_depth  = nd;
    m_fault  = nf;
    m_halted = nh;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    compare_after_edge(name);
  endtask

  task automatic idle_cycle(input string name);
    @(negedge clk);
    exp_q.push_back({m_depth, m_pc});
    checks++;
    if (op_ready !== (!m_halted && !m_fault) || stk_en !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got ready=%b stk_en=%b", name, op_ready, stk_en);
    end
    @(posedge clk);
    #1;
    compare_after_edge(name);
  endtask

  task automatic pulse_resume(input string name);
    @(negedge clk);
    resume = 1'b1;
    if (m_halted) begin
      m_pc     = m_pc + 10'd1;
      m_halted = 1'b0;
    end
    exp_q.push_back({m_depth, m_pc});
    @(posedge clk);
    #1;
    resume = 1'b0;
    compare_after_edge(name);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (pc !== 10'd0 || depth !== 6'd0 || halted !== 1'b0 || fault !== 1'b0 || stk_en !== 1'b0) begin
      errors++;
      $display("FAIL reset: got pc=%0h depth=%0d halted=%b fault=%b stk_en=%b",
               pc, depth, halted, fault, stk_en);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset op_ready: got %b expected 1", op_ready);
    end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 3; i++) send_op(3'd0, 10'h3ff, 1'b0, "nop");
  endtask

  task automatic test_branch();
    send_op(3'd2, 10'h010, 1'b0, "branch_not_taken");
    send_op(3'd1, 10'h003, 1'b0, "jump_back");
    send_op(3'd2, 10'h010, 1'b1, "branch_taken");
    for (int i = 0; i < 3; i++) idle_cycle("hold_no_op");
  endtask

  task automatic test_call_ret();
    send_op(3'd1, 10'h005, 1'b0, "jump_5");
    send_op(3'd3, 10'h040, 1'b0, "call_40");
    send_op(3'd4, 10'h000, 1'b0, "ret_to_6");
    send_op(3'd1, 10'h3ff, 1'b0, "jump_top");
    send_op(3'd0, 10'h000, 1'b0, "nop_wrap");
  endtask

  task automatic test_halt();
    send_op(3'd1, 10'h007, 1'b0, "jump_7");
    send_op(3'd5, 10'h000, 1'b0, "halt");
    for (int i = 0; i < 5; i++) send_op(3'd0, 10'h000, 1'b0, "halted_hold");
    pulse_resume("resume");
    pulse_resume("resume_in_run");
    send_op(3'd6, 10'h123, 1'b1, "opcode6_nop");
  endtask

  task automatic test_back_to_back();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: send_op(3'd0, 10'($urandom_range(0, 1023)), 1'b0, "b2b_nop");
        1: send_op(3'd1, 10'($urandom_range(0, 1023)), 1'b0, "b2b_jump");
        2: send_op(3'd2, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), "b2b_branch");
        3, 4: begin
          if (m_depth < 6'd20) send_op(3'd3, 10'($urandom_range(0, 1023)), 1'b0, "b2b_call");
          else send_op(3'd4, 10'd0, 1'b0, "b2b_ret");
        end
        default: begin
          if (m_depth > 6'd0) send_op(3'd4, 10'd0, 1'b0, "b2b_ret");
          else send_op(3'd0, 10'd0, 1'b0, "b2b_nop");
        end
      endcase
    end
    while (m_depth > 6'd0) send_op(3'd4, 10'd0, 1'b0, "b2b_unwind");
  endtask

  task automatic test_depth_limit();
    apply_reset();
    for (int i = 0; i < 63; i++) send_op(3'd3, 10'($urandom_range(0, 1023)), 1'b0, "call_fill");
    send_op(3'd3, 10'h055, 1'b0, "call_64th");
`ifdef PCSEQ_DEPTH_CHECK_EN
    checks++;
    if (fault !== 1'b1 || depth !== 6'd63) begin
      errors++;
      $display("FAIL overflow: got fault=%b depth=%0d expected fault=1 depth=63", fault, depth);
    end
    pulse_resume("resume_in_fault");
    send_op(3'd1, 10'h0aa, 1'b0, "op_in_fault");
    apply_reset();
    send_op(3'd4, 10'h000, 1'b0, "ret_underflow");
    idle_cycle("fault_frozen");
`else
    checks++;
    if (fault !== 1'b0 || depth !== 6'd0) begin
      errors++;
      $display("FAIL depth_wrap: got fault=%b depth=%0d expected fault=0 depth=0", fault, depth);
    end
`endif
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_op(3'd1, 10'h005, 1'b0, "pre_jump");
    send_op(3'd3, 10'h040, 1'b0, "pre_call");
    @(negedge clk);
    op_valid  = 1'b1;
    op_code   = 3'd3;
    op_target = 10'h080;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pc !== 10'd0 || depth !== 6'd0 || stk_en !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pc=%0h depth=%0d stk_en=%b expected 0 0 0", pc, depth, stk_en);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    send_op(3'd0, 10'h000, 1'b0, "post_reset_nop");
  endtask

  initial begin
    rst       = 1'b1;
    op_valid  = 1'b0;
    op_code   = 3'd0;
    op_target = 10'd0;
    op_cond   = 1'b0;
    resume    = 1'b0;
    model_reset();
    test_reset();
    test_nop();
    test_branch();
    test_call_ret();
    test_halt();
    test_back_to_back();
    test_depth_limit();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
